terminal_uart_tx: RTL and testbench



---
 rtl/terminal_uart_tx.sv | 151 +++++++++++++++
 tb/tb_terminal_uart_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/terminal_uart_tx.sv
// rtl/terminal_uart_tx.sv - byte FIFO feeding an 8N1 UART transmitter for the terminal peripheral
//
// Purpose: queues bytes written by the terminal peripheral and serialises them
//          on tx as 8N1 frames, LSB first, idle high.
// Ports:
//   clk       sole clock, rising edge
//   reset     synchronous active-high reset
//   wr_en     one-cycle strobe, enqueue wr_data
//   wr_data   byte to transmit
//   full      level == FIFO_DEPTH
//   empty     level == 0
//   level     bytes queued (byte in the shifter not included)
//   overflow  one-cycle pulse after a write was dropped because the FIFO was full
//   busy      transmitter FSM not idle
//   tx        registered serial output
module terminal_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [15:0]   clk_cnt, clk_cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shifter;
  logic          tx_next;
  logic          push, pop;

  assign full  = (count == LW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign busy  = (state != IDLE);
  // full is taken from the registered count, so a pop in the same cycle
  // never frees room for a write that arrives while full.
  assign push  = wr_en && !full && !reset;

  // Storage is not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shifter <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      clk_cnt <= clk_cnt_next;
      bit_idx <= bit_idx_next;
      tx      <= tx_next;
      if (pop) shifter <= mem[rd_ptr];
    end
  end

  // tx_next is the line level for the current state; registering it makes
  // the line trail the state register by one clock.
  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_idx_next = bit_idx;
    tx_next      = 1'b1;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          pop          = 1'b1;
          clk_cnt_next = '0;
          state_next   = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          clk_cnt_next = clk_cnt + 16'd1;
        end
      end
      DATA: begin
        tx_next = shifter[bit_idx];
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_next = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_next = '0;
            state_next   = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_next = clk_cnt + 16'd1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          clk_cnt_next = clk_cnt + 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_terminal_uart_tx.sv
// tb/tb_terminal_uart_tx.sv - self-checking bench for terminal_uart_tx
module tb_terminal_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       busy;
  logic       tx;

  int n_cmp;
  int n_err;
  int edge_n;
  int drop_edge;

  // Reference model: one entry per accepted byte, holding the edge it was
  // written at, the edge the transmitter takes it, and its value.
  int         qw[$];
  int         qp[$];
  logic [7:0] qd[$];

  terminal_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .busy     (busy),
    .tx       (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int m_level(input int e);
    int n;
    n = 0;
    foreach (qw[i]) if (qw[i] <= e && qp[i] > e) n++;
    return n;
  endfunction

  function automatic logic m_busy(input int e);
    foreach (qp[i]) if (e >= qp[i] && e < qp[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  // The line is low from the edge after the pop, for 10 bit times.
  function automatic logic m_tx(input int e);
    foreach (qp[i]) begin
      if (e >= qp[i] + 1 && e <= qp[i] + FRAME) begin
        int k;
        logic [7:0] b;
        k = (e - qp[i] - 1) / CPB;
        b = qd[i];
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
      end
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic step(input logic we, input logic [7:0] d, input logic rst);
    int lv;
    int lp;
    int p;
    wr_en   = we;
    wr_data = d;
    reset   = rst;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      qw.delete();
      qp.delete();
      qd.delete();
    end else if (we) begin
      lv = m_level(edge_n - 1);
      if (lv == DEPTH) begin
        drop_edge = edge_n;
      end else begin
        lp = (qp.size() == 0) ? -1000 : qp[qp.size()-1];
        p  = (edge_n + 1 > lp + FRAME + 1) ? edge_n + 1 : lp + FRAME + 1;
        qw.push_back(edge_n);
        qp.push_back(p);
        qd.push_back(d);
      end
    end
    #1;
    chk("level",    level,    m_level(edge_n));
    chk("empty",    empty,    m_level(edge_n) == 0);
    chk("full",     full,     m_level(edge_n) == DEPTH);
    chk("overflow", overflow, !rst && drop_edge == edge_n);
    chk("busy",     busy,     m_busy(edge_n));
    chk("tx",       tx,       m_tx(edge_n));
    wr_en   = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int nb;
    int e0;
    n_cmp     = 0;
    n_err     = 0;
    edge_n    = 0;
    drop_edge = -1;
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_data   = 8'h00;

    // Reset, with a write strobe that must be ignored.
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h33, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("rst_tx", tx, 1'b1);
    chk("rst_level", level, 0);
    idle(3);

    // Single 0x55 frame, busy for exactly one frame.
    step(1'b1, 8'h55, 1'b0);
    e0 = edge_n;
    chk("lat_level_n", level, 1);
    nb = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (busy) nb++;
      if (edge_n == e0 + 2) chk("lat_tx_low_n2", tx, 1'b0);
    end
    chk("busy_cycles", nb, FRAME);

    // Back-to-back 0x01, 0x80 with one idle clock between frames.
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    idle(2 * FRAME + 10);

    // 17 consecutive writes fill the FIFO, the 18th overflows.
    for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    e0 = edge_n - 16;
    step(1'b1, 8'hEE, 1'b0);
    chk("ovf_18th", overflow, 1'b1);
    chk("level_18th", level, DEPTH);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_one_cycle", overflow, 1'b0);
    // Write while full on the exact edge of the next pop: dropped.
    while (edge_n < e0 + FRAME + 1 + 1 - 1) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hDD, 1'b0);
    chk("ovf_on_pop", overflow, 1'b1);
    chk("level_on_pop", level, DEPTH - 1);
    idle(17 * (FRAME + 1) + 10);

    // Reset at data bit 3 of a frame with 5 bytes queued.
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    e0 = edge_n - 5;
    while (edge_n < e0 + 1 + 4 * CPB + 1) step(1'b0, 8'h00, 1'b0);
    chk("pre_rst_level", level, 5);
    step(1'b1, 8'h77, 1'b1);
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_level", level, 0);
    step(1'b1, 8'hA5, 1'b0);
    idle(FRAME + 10);

    // 40 paced random bytes: pointers wrap twice.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      idle($urandom_range(FRAME - 10, FRAME + 20));
    end
    idle(DEPTH * (FRAME + 1) + 10);

    // Random write density, including overflow traffic.
    for (int i = 0; i < 300; i++) step(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), 1'b0);
    idle(DEPTH * (FRAME + 1) + 10);
    chk("final_empty", empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
